// File: rtl/td4_clkgen.sv
// td4_clkgen: machine-clock generator and front-panel conditioner for the TD4 CPU.
// Latency: raw input to debounced level DB_CYC+2 cycles, debounced step edge to mclock rise 1 cycle.
// Backpressure: none; free-running outputs, the CPU core simply follows mclock.
//
// Ports:
//   clock    board clock, all logic on its rising edge
//   reset_n  asynchronous active-low reset
//   speed_n  raw switch, 0 = fast, 1 = slow
//   mode_n   raw switch, 0 = manual step, 1 = free-run
//   step_n   raw push button, 0 = pressed
//   mclock   registered machine clock to the CPU core
//   mtick    one-cycle pulse coincident with each mclock rise
//   running  1 while in a free-run state
//
// Optional feature: define TD4_CLKGEN_STEP_EN to build manual single-step mode.
// Without it mode_n/step_n are ignored and the generator only free-runs.

// Two-flop synchronizer followed by a stable-time debouncer.
module td4_clkgen_db #(
   parameter logic [31:0] DB_CYC = 32'd1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level
);
   logic        sync1;
   logic        sync2;
   logic [31:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt >= DB_CYC - 32'd1) begin
            // This is the cycle the count reaches DB_CYC: accept the new level.
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 32'd1;
         end
      end
   end
endmodule

module td4_clkgen #(
   parameter int unsigned CLK_HZ      = 24_000_000,
   parameter int unsigned SLOW_HZ     = 1,
   parameter int unsigned FAST_HZ     = 10,
   parameter int unsigned DEBOUNCE_MS = 10
) (
   input  logic clock,
   input  logic reset_n,
   input  logic speed_n,
   input  logic mode_n,
   input  logic step_n,
   output logic mclock,
   output logic mtick,
   output logic running
);
   localparam logic [31:0] HALF_SLOW = 32'(CLK_HZ / (2 * SLOW_HZ));
   localparam logic [31:0] HALF_FAST = 32'(CLK_HZ / (2 * FAST_HZ));
   localparam logic [31:0] DB_CYC    = 32'((CLK_HZ / 1000) * DEBOUNCE_MS);

   logic        speed_db;
   logic [31:0] cnt;
   logic [31:0] half_m1;
   logic        div_done;

   td4_clkgen_db #(.DB_CYC(DB_CYC)) u_speed_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (speed_n),
      .level   (speed_db)
   );

   // Terminal count follows the debounced speed every cycle, so a switch to
   // fast while the count is already past the new terminal toggles at once.
   assign half_m1  = speed_db ? (HALF_SLOW - 32'd1) : (HALF_FAST - 32'd1);
   assign div_done = (cnt >= half_m1);

`ifdef TD4_CLKGEN_STEP_EN
   typedef enum logic [1:0] {RUN_LOW, RUN_HIGH, STEP_IDLE, STEP_HIGH} state_t;

   state_t state;
   logic   mode_db;
   logic   step_db;
   logic   step_prev;
   logic   step_fall;

   td4_clkgen_db #(.DB_CYC(DB_CYC)) u_mode_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (mode_n),
      .level   (mode_db)
   );

   td4_clkgen_db #(.DB_CYC(DB_CYC)) u_step_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (step_n),
      .level   (step_db)
   );

   // step_prev tracks in every state, so an edge seen during STEP_HIGH is
   // consumed there and a held button never produces a second step.
   assign step_fall = step_prev & ~step_db;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN_LOW;
         cnt       <= '0;
         mclock    <= 1'b0;
         mtick     <= 1'b0;
         running   <= 1'b1;
         step_prev <= 1'b1;
      end else begin
         step_prev <= step_db;
         mtick     <= 1'b0;
         case (state)
            RUN_LOW: begin
               // A due toggle beats a pending mode change.
               if (div_done) begin
                  state  <= RUN_HIGH;
                  cnt    <= '0;
                  mclock <= 1'b1;
                  mtick  <= 1'b1;
               end else if (!mode_db) begin
                  state   <= STEP_IDLE;
                  cnt     <= '0;
                  running <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RUN_HIGH: begin
               // The high half always completes; mode is only sampled at its end.
               if (div_done) begin
                  cnt    <= '0;
                  mclock <= 1'b0;
                  if (mode_db) begin
                     state <= RUN_LOW;
                  end else begin
                     state   <= STEP_IDLE;
                     running <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            STEP_IDLE: begin
               cnt <= '0;
               if (mode_db) begin
                  state   <= RUN_LOW;
                  running <= 1'b1;
               end else if (step_fall) begin
                  state  <= STEP_HIGH;
                  mclock <= 1'b1;
                  mtick  <= 1'b1;
               end
            end
            STEP_HIGH: begin
               // Step pulse width is always the fast half period.
               if (cnt >= HALF_FAST - 32'd1) begin
                  cnt    <= '0;
                  mclock <= 1'b0;
                  if (mode_db) begin
                     state   <= RUN_LOW;
                     running <= 1'b1;
                  end else begin
                     state <= STEP_IDLE;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: begin
               state   <= RUN_LOW;
               cnt     <= '0;
               mclock  <= 1'b0;
               running <= 1'b1;
            end
         endcase
      end
   end
`else
   typedef enum logic {RUN_LOW, RUN_HIGH} state_t;

   state_t state;
   logic   unused_inputs;

   // Manual-mode inputs have no function in this build.
   assign unused_inputs = mode_n ^ step_n;
   assign running       = 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= RUN_LOW;
         cnt    <= '0;
         mclock <= 1'b0;
         mtick  <= 1'b0;
      end else begin
         mtick <= 1'b0;
         if (div_done) begin
            cnt <= '0;
            if (state == RUN_LOW) begin
               state  <= RUN_HIGH;
               mclock <= 1'b1;
               mtick  <= 1'b1;
            end else begin
               state  <= RUN_LOW;
               mclock <= 1'b0;
            end
         end else begin
            cnt <= cnt + 32'd1;
         end
      end
   end
`endif
endmodule
